// File: rtl/mag_cook_sequencer.sv
// Microwave cook sequencer: BCD MM:SS keypad entry, one-second countdown,
// and a power-level duty-cycled magnetron enable.
module mag_cook_sequencer #(
  parameter int unsigned CLK_PER_SEC = 50_000_000,
  parameter int unsigned DUTY_WINDOW = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       startn,
  input  logic       stopn,
  input  logic       clearn,
  input  logic       door_closed,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic [3:0] power_level,
  output logic       mag_on,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [2:0] state,
  output logic       done_pulse
);

  localparam int unsigned CW = $clog2(CLK_PER_SEC);
  localparam int unsigned PW = $clog2(DUTY_WINDOW + 1);
  localparam logic [CW-1:0] PRESC_MAX  = CW'(CLK_PER_SEC - 1);
  localparam logic [PW-1:0] DUTY_MAX   = PW'(DUTY_WINDOW - 1);
  localparam logic [PW-1:0] FULL_POWER = PW'(DUTY_WINDOW);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SET   = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   time_q, time_d;
  logic [CW-1:0] presc_q, presc_d;
  logic [PW-1:0] duty_q, duty_d;
  logic [PW-1:0] power_q, power_d;
  logic          done_q, done_d;
  logic          start_prev, stop_prev, clear_prev, door_prev;

  logic          start_ev, stop_ev, clear_ev, door_fall, tick;
  logic [15:0]   time_dec;
  logic [31:0]   power_ext;
  logic [PW-1:0] power_sel;

  // Time is held as {min_tens, min_ones, sec_tens, sec_ones}; seconds above
  // 59 simply count down digit-wise until they reach 00.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[7:0] != 8'h00) begin
      if (t[3:0] == 4'd0) begin
        r[3:0] = 4'd9;
        r[7:4] = t[7:4] - 4'd1;
      end else begin
        r[3:0] = t[3:0] - 4'd1;
      end
    end else begin
      r[7:0] = 8'h59;
      if (t[11:8] == 4'd0) begin
        r[11:8]  = 4'd9;
        r[15:12] = t[15:12] - 4'd1;
      end else begin
        r[11:8] = t[11:8] - 4'd1;
      end
    end
    return r;
  endfunction

  assign start_ev  = start_prev & ~startn;
  assign stop_ev   = stop_prev & ~stopn;
  assign clear_ev  = clear_prev & ~clearn;
  assign door_fall = door_prev & ~door_closed;
  assign tick      = (state_q == COOK) && (presc_q == PRESC_MAX);
  assign time_dec  = bcd_dec(time_q);
  assign power_ext = 32'(power_level);
  assign power_sel = (power_ext == 32'd0 || power_ext > DUTY_WINDOW) ? FULL_POWER : PW'(power_ext);

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    presc_d = presc_q;
    duty_d  = duty_q;
    power_d = power_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, SET: begin
        if (clear_ev) begin
          state_d = IDLE;
          time_d  = '0;
        end else if (start_ev && !stop_ev && door_closed && time_q != '0) begin
          state_d = COOK;
          power_d = power_sel;
          presc_d = '0;
          duty_d  = '0;
        end else if (key_valid && key_digit <= 4'd9) begin
          state_d = SET;
          time_d  = {time_q[11:0], key_digit};
        end
      end
      COOK: begin
        if (clear_ev) begin
          state_d = IDLE;
          time_d  = '0;
        end else if (stop_ev || !door_closed) begin
          state_d = PAUSE;
          presc_d = '0;
        end else if (tick) begin
          presc_d = '0;
          duty_d  = (duty_q == DUTY_MAX) ? '0 : duty_q + 1'b1;
          time_d  = time_dec;
          if (time_dec == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      PAUSE: begin
        if (clear_ev || stop_ev) begin
          state_d = IDLE;
          time_d  = '0;
        end else if (start_ev && door_closed) begin
          state_d = COOK;
        end
      end
      DONE: begin
        time_d = '0;
        if (start_ev || stop_ev || clear_ev || door_fall) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        time_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      time_q     <= '0;
      presc_q    <= '0;
      duty_q     <= '0;
      power_q    <= FULL_POWER;
      done_q     <= 1'b0;
      start_prev <= 1'b1;
      stop_prev  <= 1'b1;
      clear_prev <= 1'b1;
      door_prev  <= 1'b0;
    end else begin
      state_q    <= state_d;
      time_q     <= time_d;
      presc_q    <= presc_d;
      duty_q     <= duty_d;
      power_q    <= power_d;
      done_q     <= done_d;
      start_prev <= startn;
      stop_prev  <= stopn;
      clear_prev <= clearn;
      door_prev  <= door_closed;
    end
  end

  // Door gating is combinational so opening the door cuts power immediately.
  assign mag_on     = (state_q == COOK) && door_closed && (duty_q < power_q);
  assign min_tens   = time_q[15:12];
  assign min_ones   = time_q[11:8];
  assign sec_tens   = time_q[7:4];
  assign sec_ones   = time_q[3:0];
  assign state      = state_q;
  assign done_pulse = done_q;

endmodule

// File: tb/tb_mag_cook_sequencer.sv
// Self-checking bench for mag_cook_sequencer: directed scenarios followed by
// random key/door/power activity, all checked against a seconds-level model.
module tb_mag_cook_sequencer;

  localparam int unsigned CPS = 4;
  localparam int unsigned DW  = 10;
  localparam int ST_IDLE = 0, ST_SET = 1, ST_COOK = 2, ST_PAUSE = 3, ST_DONE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       startn = 1'b1, stopn = 1'b1, clearn = 1'b1;
  logic       door_closed = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic [3:0] power_level = 4'd10;
  logic       mag_on, done_pulse;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [2:0] state;

  mag_cook_sequencer #(.CLK_PER_SEC(CPS), .DUTY_WINDOW(DW)) dut (
    .clk(clk), .rst(rst), .startn(startn), .stopn(stopn), .clearn(clearn),
    .door_closed(door_closed), .key_valid(key_valid), .key_digit(key_digit),
    .power_level(power_level), .mag_on(mag_on),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .state(state), .done_pulse(done_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: time as plain minute/second numbers, cycles within the
  // current second, seconds elapsed within the duty window.
  int m_state, m_min, m_sec, m_presc, m_duty, m_power;
  bit m_done, m_ps, m_pt, m_pc, m_pd;
  bit m_valid = 1'b0;
  int mag_cnt = 0, done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_time();
    return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
  endfunction

  function automatic logic exp_mag();
    return (m_state == ST_COOK) && door_closed && (m_duty < m_power);
  endfunction

  function automatic logic [15:0] obs_time();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic model_update();
    bit se, te, ce, df, fin;
    int n;
    if (rst) begin
      m_state = ST_IDLE; m_min = 0; m_sec = 0; m_presc = 0; m_duty = 0;
      m_power = DW; m_done = 0; m_ps = 1; m_pt = 1; m_pc = 1; m_pd = 0;
      m_valid = 1'b1;
      return;
    end
    se = m_ps && !startn;
    te = m_pt && !stopn;
    ce = m_pc && !clearn;
    df = m_pd && !door_closed;
    fin = 0;
    case (m_state)
      ST_IDLE, ST_SET: begin
        if (ce) begin
          m_state = ST_IDLE; m_min = 0; m_sec = 0;
        end else if (se && !te && door_closed && (m_min * 100 + m_sec) != 0) begin
          m_state = ST_COOK;
          m_power = (power_level == 0 || power_level > DW) ? DW : int'(power_level);
          m_presc = 0; m_duty = 0;
        end else if (key_valid && key_digit <= 9) begin
          n = ((m_min * 100 + m_sec) * 10 + int'(key_digit)) % 10000;
          m_min = n / 100; m_sec = n % 100; m_state = ST_SET;
        end
      end
      ST_COOK: begin
        if (ce) begin
          m_state = ST_IDLE; m_min = 0; m_sec = 0;
        end else if (te || !door_closed) begin
          m_state = ST_PAUSE; m_presc = 0;
        end else if (m_presc == CPS - 1) begin
          m_presc = 0;
          m_duty = (m_duty + 1) % DW;
          if (m_sec > 0) m_sec--;
          else begin m_min--; m_sec = 59; end
          if (m_min == 0 && m_sec == 0) begin m_state = ST_DONE; fin = 1; end
        end else begin
          m_presc++;
        end
      end
      ST_PAUSE: begin
        if (ce || te) begin
          m_state = ST_IDLE; m_min = 0; m_sec = 0;
        end else if (se && door_closed) begin
          m_state = ST_COOK;
        end
      end
      default: begin
        if (se || te || ce || df) m_state = ST_IDLE;
      end
    endcase
    m_done = fin;
    m_ps = startn; m_pt = stopn; m_pc = clearn; m_pd = door_closed;
  endtask

  // One clock: mag_on sampled at the falling edge, registered outputs #1 after rising.
  task automatic cyc();
    @(negedge clk);
    if (m_valid) chk("mag_on", 32'(mag_on), 32'(exp_mag()));
    if (mag_on === 1'b1) mag_cnt++;
    @(posedge clk);
    model_update();
    #1;
    if (m_valid) begin
      chk("state", 32'(state), 32'(m_state));
      chk("time", 32'(obs_time()), 32'(exp_time()));
      chk("done_pulse", 32'(done_pulse), 32'(m_done));
    end
    if (done_pulse === 1'b1) done_cnt++;
  endtask

  task automatic press_digit(input logic [3:0] d);
    key_valid = 1'b1; key_digit = d; cyc();
    key_valid = 1'b0; cyc();
  endtask

  task automatic press_start();
    startn = 1'b0; cyc(); startn = 1'b1; cyc();
  endtask

  task automatic press_clear();
    clearn = 1'b0; cyc(); clearn = 1'b1; cyc();
  endtask

  initial begin
    int n, mag10, resumes;
    logic [2:0] prev;

    // Reset
    rst = 1'b1; cyc(); cyc();
    rst = 1'b0; cyc();
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_time", 32'(obs_time()), 32'h0000);

    // 1: 01:05 at full power runs 65 s then DONE with one pulse
    press_digit(4'd1); press_digit(4'd0); press_digit(4'd5);
    chk("t1_entry", 32'(obs_time()), 32'h0105);
    chk("t1_set", 32'(state), 32'd1);
    startn = 1'b0; cyc(); startn = 1'b1;
    chk("t1_cook", 32'(state), 32'd2);
    n = 0; mag_cnt = 0; done_cnt = 0;
    while (state !== 3'd4 && n < 400) begin cyc(); n++; end
    chk("t1_cycles", 32'(n), 32'd260);
    chk("t1_mag_cycles", 32'(mag_cnt), 32'd260);
    cyc(); cyc(); cyc();
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    chk("t1_mag_off", 32'(mag_on), 32'd0);
    chk("t1_still_done", 32'(state), 32'd4);
    press_clear();
    chk("t1_idle", 32'(state), 32'd0);

    // 2: 00:12 at power 3 -> 3 on-seconds per 10-second window
    power_level = 4'd3;
    press_digit(4'd1); press_digit(4'd2);
    chk("t2_entry", 32'(obs_time()), 32'h0012);
    startn = 1'b0; cyc(); startn = 1'b1;
    n = 0; mag_cnt = 0; mag10 = 0;
    while (state !== 3'd4 && n < 400) begin
      cyc(); n++;
      if (n == 40) mag10 = mag_cnt;
    end
    chk("t2_cycles", 32'(n), 32'd48);
    chk("t2_mag_window", 32'(mag10), 32'd12);
    chk("t2_mag_total", 32'(mag_cnt), 32'd20);
    press_clear();

    // 3: door opens at 00:20 -> pause, start ignored with door open, resume
    power_level = 4'd10;
    press_digit(4'd3); press_digit(4'd0);
    startn = 1'b0; cyc(); startn = 1'b1;
    repeat (40) cyc();
    chk("t3_at20", 32'(obs_time()), 32'h0020);
    door_closed = 1'b0; #1;
    chk("t3_mag_drop", 32'(mag_on), 32'd0);
    cyc();
    chk("t3_pause", 32'(state), 32'd3);
    chk("t3_held", 32'(obs_time()), 32'h0020);
    startn = 1'b0; cyc(); startn = 1'b1; cyc();
    chk("t3_open_start", 32'(state), 32'd3);
    door_closed = 1'b1; cyc();
    startn = 1'b0; cyc(); startn = 1'b1;
    chk("t3_resume", 32'(state), 32'd2);
    chk("t3_resume_time", 32'(obs_time()), 32'h0020);
    press_clear();

    // 4: start and clear together in SET -> clear wins; start at 0000 ignored
    press_digit(4'd5);
    mag_cnt = 0;
    startn = 1'b0; clearn = 1'b0; cyc();
    chk("t4_clear_wins", 32'(state), 32'd0);
    chk("t4_zero", 32'(obs_time()), 32'h0000);
    startn = 1'b1; clearn = 1'b1; cyc();
    press_start();
    chk("t4_zero_start", 32'(state), 32'd0);
    chk("t4_no_mag", 32'(mag_cnt), 32'd0);

    // 5: held start during PAUSE resumes once; stop from PAUSE -> IDLE
    press_digit(4'd2); press_digit(4'd0);
    press_start();
    repeat (6) cyc();
    stopn = 1'b0; cyc(); stopn = 1'b1; cyc();
    chk("t5_pause", 32'(state), 32'd3);
    startn = 1'b0; resumes = 0;
    for (int i = 0; i < 20; i++) begin
      prev = state; cyc();
      if (prev == 3'd3 && state == 3'd2) resumes++;
    end
    startn = 1'b1; cyc();
    chk("t5_resumes", 32'(resumes), 32'd1);
    chk("t5_cooking", 32'(state), 32'd2);
    stopn = 1'b0; cyc(); stopn = 1'b1; cyc();
    chk("t5_pause2", 32'(state), 32'd3);
    stopn = 1'b0; cyc(); stopn = 1'b1; cyc();
    chk("t5_idle", 32'(state), 32'd0);
    chk("t5_zero", 32'(obs_time()), 32'h0000);

    // 6: reset while cooking at 00:07
    press_digit(4'd1); press_digit(4'd0);
    press_start();
    repeat (11) cyc();
    chk("t6_at07", 32'(obs_time()), 32'h0007);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("t6_state", 32'(state), 32'd0);
    chk("t6_time", 32'(obs_time()), 32'h0000);
    chk("t6_mag", 32'(mag_on), 32'd0);
    chk("t6_done", 32'(done_pulse), 32'd0);
    cyc();

    // Random activity against the model
    for (int i = 0; i < 4000; i++) begin
      rst         = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 7) == 0)  startn = ~startn;
      if ($urandom_range(0, 19) == 0) stopn = ~stopn;
      if ($urandom_range(0, 39) == 0) clearn = ~clearn;
      if ($urandom_range(0, 59) == 0) door_closed = ~door_closed;
      key_valid   = ($urandom_range(0, 5) == 0);
      key_digit   = 4'($urandom_range(0, 12));
      power_level = 4'($urandom_range(0, 15));
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
